// File: rtl/ahb_slave_mem_pkg.sv
// ahb_slave_mem_pkg: AHB bus types, wait-mode selectors and slave FSM states
package ahb_slave_mem_pkg;
   typedef enum logic [1:0] {HT_IDLE, HT_BUSY, HT_NONSEQ, HT_SEQ} t_htrans;
   typedef enum logic [2:0] {HS_BYTE, HS_HALF, HS_WORD, HS_DWORD, HS_4W, HS_8W, HS_16W, HS_32W} t_hsize;
   typedef enum logic [1:0] {HR_OKAY, HR_ERROR, HR_RETRY, HR_SPLIT} t_hresp;
   typedef enum logic [2:0] {HB_SINGLE, HB_INCR, HB_WRAP4, HB_INCR4, HB_WRAP8, HB_INCR8, HB_WRAP16, HB_INCR16} t_hburst;
   localparam int WAIT_NONE = 0;
   localparam int WAIT_FIXED = 1;
   localparam int WAIT_RAND = 2;
   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} t_slv_state;
   // Galois step for x^16+x^14+x^13+x^11+1, shifting right
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction
endpackage

// File: rtl/ahb_slave_mem_if.sv
// ahb_slave_mem_if: AHB slave-side bus bundle
interface ahb_slave_mem_if #(parameter int DATA_WDT = 32);
   logic i_hsel;
   logic [31:0] i_haddr;
   logic [1:0] i_htrans;
   logic i_hwrite;
   logic [2:0] i_hsize;
   logic [2:0] i_hburst;
   logic [DATA_WDT-1:0] i_hwdata;
   logic i_hready;
   logic [DATA_WDT-1:0] o_hrdata;
   logic o_hreadyout;
   logic [1:0] o_hresp;
   modport slave (
      input i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst, i_hwdata, i_hready,
      output o_hrdata, o_hreadyout, o_hresp
   );
   modport master (
      output i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst, i_hwdata, i_hready,
      input o_hrdata, o_hreadyout, o_hresp
   );
endinterface

// File: rtl/ahb_slave_lfsr.sv
// ahb_slave_lfsr: free-running 16-bit Galois LFSR for wait-state generation
module ahb_slave_lfsr
   import ahb_slave_mem_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        i_hclk,
   input  logic        i_hreset,
   output logic [15:0] o_lfsr
);
   always_ff @(posedge i_hclk)
      if (i_hreset) o_lfsr <= SEED;
      else o_lfsr <= lfsr_next(o_lfsr);
endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: parametrised AHB slave memory with byte lanes, wait states and ERROR response
module ahb_slave_mem
   import ahb_slave_mem_pkg::*;
#(
   parameter int          DATA_WDT    = 32,
   parameter int          MEM_WORDS   = 64,
   parameter int          WAIT_MODE   = 0,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input logic i_hclk,
   input logic i_hreset,
   ahb_slave_mem_if.slave bus
);
   localparam int NB = DATA_WDT / 8;
   localparam int LB = $clog2(NB);
   localparam int WW = $clog2(MEM_WORDS);
   localparam int MEM_BYTES = MEM_WORDS * NB;
   t_slv_state state, state_nx;
   logic [3:0] cnt, cnt_nx, load;
   logic [15:0] lfsr;
   logic rdy, acc, bad, write_q;
   logic [2:0] size_q;
   logic [LB-1:0] lane_q;
   logic [WW-1:0] word_q;
   logic [NB-1:0] be;
   logic [DATA_WDT-1:0] mem [MEM_WORDS];
   logic unused;
   ahb_slave_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.i_hclk(i_hclk), .i_hreset(i_hreset), .o_lfsr(lfsr));
   assign unused = ^{bus.i_hburst, lfsr[15:2]};
   assign rdy = !(state == ST_WAIT || state == ST_ERR1);
   assign acc = bus.i_hsel & bus.i_hready & rdy & bus.i_htrans[1];
   assign bad = (bus.i_haddr >= 32'(MEM_BYTES)) | (bus.i_hsize > 3'(LB)) |
                (|(bus.i_haddr[7:0] & ((8'd1 << bus.i_hsize) - 8'd1)));
   assign load = WAIT_MODE == WAIT_FIXED ? 4'(WAIT_CYCLES) :
                 WAIT_MODE == WAIT_RAND ? {2'b00, lfsr[1:0]} : 4'd0;
   // lane mask: (1 << bytes) - 1 wraps to all ones for a full-width beat
   assign be = ((NB'(1) << (NB'(1) << size_q)) - NB'(1)) << lane_q;
   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      if (state == ST_WAIT) begin
         cnt_nx = cnt - 4'd1;
         state_nx = cnt == 4'd1 ? ST_DATA : ST_WAIT;
      end else if (state == ST_ERR1) state_nx = ST_ERR2;
      else if (acc) begin
         state_nx = bad ? ST_ERR1 : load != 4'd0 ? ST_WAIT : ST_DATA;
         cnt_nx = bad ? 4'd0 : load;
      end else state_nx = ST_IDLE;
      bus.o_hreadyout = rdy;
      bus.o_hresp = (state == ST_ERR1 || state == ST_ERR2) ? HR_ERROR : HR_OKAY;
      bus.o_hrdata = state == ST_DATA ? mem[word_q] : '0;
   end
   always_ff @(posedge i_hclk)
      if (i_hreset) begin
         state <= ST_IDLE;
         cnt <= 4'd0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         if (acc) begin
            write_q <= bus.i_hwrite;
            size_q <= bus.i_hsize;
            lane_q <= bus.i_haddr[LB-1:0];
            word_q <= bus.i_haddr[LB +: WW];
         end
      end
   // memory has no reset; a reset edge still suppresses a pending write
   always_ff @(posedge i_hclk)
      if (!i_hreset && state == ST_DATA && write_q)
         for (int b = 0; b < NB; b++)
            if (be[b]) mem[word_q][b*8 +: 8] <= bus.i_hwdata[b*8 +: 8];
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: directed and scoreboarded checks over no-wait, fixed-wait and random-wait slaves
module tb_ahb_slave_mem;
   import ahb_slave_mem_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic hsel_d = 1'b0;
   int sel = 0;
   logic [31:0] haddr = '0, hwdata = '0;
   logic [1:0] htrans = '0;
   logic hwrite = 1'b0;
   logic [2:0] hsize = '0, hburst = '0;
   logic rdy;
   logic [31:0] rdata;
   logic [1:0] resp;
   int nchk = 0, nerr = 0;
   int nb = 0, cyc = 0;
   logic [1:0] b_tr [64];
   logic b_wr [64];
   logic [2:0] b_sz [64];
   logic [31:0] b_addr [64], b_wd [64], e_rd [64], o_rd [64];
   logic e_err [64];
   logic [1:0] o_rsp0 [64], o_rsp [64];
   int o_wait [64];
   logic [7:0] mdl [64];
   ahb_slave_mem_if #(.DATA_WDT(32)) b0 (), b1 (), b2 ();
   assign b0.i_hsel = hsel_d & (sel == 0);
   assign b1.i_hsel = hsel_d & (sel == 1);
   assign b2.i_hsel = hsel_d & (sel == 2);
   assign {b0.i_haddr, b1.i_haddr, b2.i_haddr} = {3{haddr}};
   assign {b0.i_htrans, b1.i_htrans, b2.i_htrans} = {3{htrans}};
   assign {b0.i_hwrite, b1.i_hwrite, b2.i_hwrite} = {3{hwrite}};
   assign {b0.i_hsize, b1.i_hsize, b2.i_hsize} = {3{hsize}};
   assign {b0.i_hburst, b1.i_hburst, b2.i_hburst} = {3{hburst}};
   assign {b0.i_hwdata, b1.i_hwdata, b2.i_hwdata} = {3{hwdata}};
   assign b0.i_hready = b0.o_hreadyout;
   assign b1.i_hready = b1.o_hreadyout;
   assign b2.i_hready = b2.o_hreadyout;
   assign rdy = sel == 0 ? b0.o_hreadyout : sel == 1 ? b1.o_hreadyout : b2.o_hreadyout;
   assign rdata = sel == 0 ? b0.o_hrdata : sel == 1 ? b1.o_hrdata : b2.o_hrdata;
   assign resp = sel == 0 ? b0.o_hresp : sel == 1 ? b1.o_hresp : b2.o_hresp;
   ahb_slave_mem #(.DATA_WDT(32), .MEM_WORDS(64), .WAIT_MODE(WAIT_NONE), .WAIT_CYCLES(2), .LFSR_SEED(16'hACE1))
      u_nowait (.i_hclk(clk), .i_hreset(rst), .bus(b0));
   ahb_slave_mem #(.DATA_WDT(32), .MEM_WORDS(64), .WAIT_MODE(WAIT_FIXED), .WAIT_CYCLES(3), .LFSR_SEED(16'hACE1))
      u_fixed (.i_hclk(clk), .i_hreset(rst), .bus(b1));
   ahb_slave_mem #(.DATA_WDT(32), .MEM_WORDS(64), .WAIT_MODE(WAIT_RAND), .WAIT_CYCLES(2), .LFSR_SEED(16'hACE1))
      u_rand (.i_hclk(clk), .i_hreset(rst), .bus(b2));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] tr, input logic w, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input logic err);
      b_tr[nb] = tr; b_wr[nb] = w; b_sz[nb] = sz; b_addr[nb] = a;
      b_wd[nb] = wd; e_rd[nb] = rd; e_err[nb] = err;
      nb++;
   endtask

   task automatic drive(input int i);
      hsel_d = 1'b1; haddr = b_addr[i]; htrans = b_tr[i]; hwrite = b_wr[i]; hsize = b_sz[i];
   endtask

   // pipelined master: next address phase overlaps the current data phase
   task automatic run();
      int nxt, done, w;
      logic ok;
      drive(0);
      @(posedge clk); #1;
      nxt = 1; done = 0; w = 0; cyc = 0;
      while (done < nb && cyc < 2000) begin
         if (nxt < nb) drive(nxt);
         else begin hsel_d = 1'b0; htrans = HT_IDLE; end
         hwdata = b_wd[done];
         if (w == 0) o_rsp0[done] = resp;
         ok = rdy;
         if (ok) begin o_rd[done] = rdata; o_rsp[done] = resp; o_wait[done] = w; end
         @(posedge clk); #1;
         cyc++;
         if (ok) begin done++; w = 0; if (nxt < nb) nxt++; end
         else w++;
      end
      hsel_d = 1'b0; htrans = HT_IDLE;
      check("run_complete", 32'(done), 32'(nb));
   endtask

   task automatic verify(input string grp, input int ew);
      for (int i = 0; i < nb; i++) begin
         if (e_err[i]) begin
            check($sformatf("%s_err_c1[%0d]", grp, i), {30'b0, o_rsp0[i]}, 32'd1);
            check($sformatf("%s_err_c2[%0d]", grp, i), {30'b0, o_rsp[i]}, 32'd1);
            check($sformatf("%s_err_len[%0d]", grp, i), 32'(o_wait[i]), 32'd1);
         end else begin
            check($sformatf("%s_okay[%0d]", grp, i), {30'b0, o_rsp[i]}, 32'd0);
            if (ew >= 0) check($sformatf("%s_waits[%0d]", grp, i), 32'(o_wait[i]), 32'(ew));
            else check($sformatf("%s_wait_rng[%0d]", grp, i), {31'b0, o_wait[i] <= 3}, 32'd1);
            if (!b_wr[i] || !b_tr[i][1]) check($sformatf("%s_rdata[%0d]", grp, i), o_rd[i], e_rd[i]);
         end
      end
      nb = 0;
   endtask

   initial begin
      int maxw;
      logic [31:0] v, a;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sel = k;
         #1;
         check($sformatf("rst_ready%0d", k), {31'b0, rdy}, 32'd1);
         check($sformatf("rst_resp%0d", k), {30'b0, resp}, 32'd0);
         check($sformatf("rst_rdata%0d", k), rdata, 32'd0);
      end
      @(posedge clk); #1;
      // no-wait slave: data, byte lanes, BUSY, error cases and top word
      sel = 0; hburst = HB_SINGLE;
      add(HT_NONSEQ, 1, 2, 32'h10, 32'hDEADBEEF, 0, 0);
      add(HT_NONSEQ, 0, 2, 32'h10, 0, 32'hDEADBEEF, 0);
      add(HT_NONSEQ, 1, 2, 32'h10, 32'h11223344, 0, 0);
      add(HT_NONSEQ, 1, 0, 32'h13, 32'hAA000000, 0, 0);
      add(HT_NONSEQ, 0, 2, 32'h10, 0, 32'hAA223344, 0);
      add(HT_BUSY,   1, 2, 32'h10, 32'h12345678, 32'h0, 0);
      add(HT_NONSEQ, 0, 2, 32'h10, 0, 32'hAA223344, 0);
      add(HT_NONSEQ, 1, 2, 32'h00, 32'h0BADF00D, 0, 0);
      add(HT_NONSEQ, 0, 2, 32'h400, 0, 0, 1);
      add(HT_NONSEQ, 1, 2, 32'h02, 32'hFFFFFFFF, 0, 1);
      add(HT_NONSEQ, 1, 3, 32'h08, 32'hFFFFFFFF, 0, 1);
      add(HT_NONSEQ, 0, 2, 32'h00, 0, 32'h0BADF00D, 0);
      add(HT_NONSEQ, 1, 1, 32'h12, 32'hBEEF0000, 0, 0);
      add(HT_NONSEQ, 0, 2, 32'h10, 0, 32'hBEEF3344, 0);
      add(HT_NONSEQ, 1, 0, 32'h01, 32'h00005A00, 0, 0);
      add(HT_NONSEQ, 0, 2, 32'h00, 0, 32'h0BAD5A0D, 0);
      add(HT_NONSEQ, 1, 2, 32'hFC, 32'hCAFEBABE, 0, 0);
      add(HT_NONSEQ, 0, 2, 32'hFC, 0, 32'hCAFEBABE, 0);
      add(HT_NONSEQ, 0, 2, 32'h100, 0, 0, 1);
      add(HT_NONSEQ, 1, 1, 32'h11, 32'hFFFFFFFF, 0, 1);
      add(HT_NONSEQ, 0, 2, 32'h10, 0, 32'hBEEF3344, 0);
      run();
      verify("nowait", 0);
      // fixed three-wait slave: fill, INCR4 read burst, error, reset during a wait
      sel = 1;
      add(HT_NONSEQ, 1, 2, 32'h40, 32'h01020304, 0, 0);
      add(HT_NONSEQ, 1, 2, 32'h44, 32'h05060708, 0, 0);
      add(HT_NONSEQ, 1, 2, 32'h48, 32'h090A0B0C, 0, 0);
      add(HT_NONSEQ, 1, 2, 32'h4C, 32'h0D0E0F10, 0, 0);
      add(HT_NONSEQ, 0, 2, 32'h400, 0, 0, 1);
      run();
      verify("fixed_wr", 3);
      hburst = HB_INCR4;
      add(HT_NONSEQ, 0, 2, 32'h40, 0, 32'h01020304, 0);
      add(HT_SEQ,    0, 2, 32'h44, 0, 32'h05060708, 0);
      add(HT_SEQ,    0, 2, 32'h48, 0, 32'h090A0B0C, 0);
      add(HT_SEQ,    0, 2, 32'h4C, 0, 32'h0D0E0F10, 0);
      run();
      check("burst_cycles", 32'(cyc), 32'd16);
      verify("fixed_burst", 3);
      hburst = HB_SINGLE;
      hsel_d = 1'b1; haddr = 32'h40; htrans = HT_NONSEQ; hwrite = 1'b1; hsize = 3'd2;
      @(posedge clk); #1;
      hsel_d = 1'b0; htrans = HT_IDLE; hwdata = 32'h99999999;
      check("in_wait_ready", {31'b0, rdy}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("post_rst_ready", {31'b0, rdy}, 32'd1);
      check("post_rst_resp", {30'b0, resp}, 32'd0);
      add(HT_NONSEQ, 0, 2, 32'h40, 0, 32'h01020304, 0);
      run();
      verify("fixed_rst", 3);
      // random-wait slave against a byte-level scoreboard
      sel = 2;
      for (int i = 0; i < 16; i++) begin
         v = $urandom;
         add(HT_NONSEQ, 1, 2, 32'(4 * i), v, 0, 0);
         for (int j = 0; j < 4; j++) mdl[4 * i + j] = v[8 * j +: 8];
      end
      for (int k = 0; k < 40; k++) begin
         int kind, wi, sz;
         kind = $urandom_range(0, 3);
         wi = $urandom_range(0, 15);
         v = $urandom;
         if (kind == 0)
            add(HT_NONSEQ, 0, 2, 32'(4 * wi), 0, {mdl[4*wi+3], mdl[4*wi+2], mdl[4*wi+1], mdl[4*wi]}, 0);
         else begin
            sz = 3 - kind;
            a = 32'(4 * wi + (sz == 1 ? 2 * $urandom_range(0, 1) : sz == 0 ? $urandom_range(0, 3) : 0));
            add(HT_NONSEQ, 1, 3'(sz), a, v, 0, 0);
            for (int j = 0; j < (1 << sz); j++) mdl[a + j] = v[8 * ((a + j) % 4) +: 8];
         end
      end
      run();
      maxw = 0;
      for (int i = 0; i < nb; i++) if (o_wait[i] > maxw) maxw = o_wait[i];
      check("rand_some_waits", {31'b0, maxw > 0}, 32'd1);
      verify("rand", -1);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
